// File: rtl/vend_ctrl_n_pkg.sv
// ---------------------------------------------------------------------------
// vend_ctrl_n_pkg : shared state encoding and coin denomination constants
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vend_ctrl_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // Coin values and their one-hot codes on the coin / chg_coin buses
  localparam logic [3:0] C_COIN_1  = 4'd1;
  localparam logic [3:0] C_COIN_2  = 4'd2;
  localparam logic [3:0] C_COIN_5  = 4'd5;
  localparam logic [3:0] C_COIN_10 = 4'd10;

  localparam logic [3:0] C_CODE_1  = 4'b0001;
  localparam logic [3:0] C_CODE_2  = 4'b0010;
  localparam logic [3:0] C_CODE_5  = 4'b0100;
  localparam logic [3:0] C_CODE_10 = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/vend_ctrl_n_if.sv
// ---------------------------------------------------------------------------
// vend_ctrl_n_if : customer-side controls and display/payout signals
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vend_ctrl_n_if #(
  parameter int N_ITEMS = 4,
  parameter int VAL_W   = 7,
  parameter int TOT_W   = 10
);
  logic [N_ITEMS-1:0] sel;
  logic [3:0]         coin;
  logic               confirm;
  logic               cancel;
  logic               reset_total;
  logic [VAL_W-1:0]   price;
  logic [VAL_W-1:0]   balance;
  logic [VAL_W-1:0]   change;
  logic [N_ITEMS-1:0] vend_item;
  logic               alarm;
  logic               busy;
  logic [3:0]         chg_coin;
  logic [TOT_W-1:0]   total;

  modport master (
    output sel, coin, confirm, cancel, reset_total,
    input  price, balance, change, vend_item, alarm, busy, chg_coin, total
  );

  modport slave (
    input  sel, coin, confirm, cancel, reset_total,
    output price, balance, change, vend_item, alarm, busy, chg_coin, total
  );
endinterface

`default_nettype wire

// File: rtl/vend_change_disp.sv
// ---------------------------------------------------------------------------
// vend_change_disp : greedy change payout, one coin pulse per cycle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_change_disp
  import vend_ctrl_n_pkg::*;
#(
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VAL_W-1:0] amount,
  output logic [3:0]       chg_coin,
  output logic             done
);

  logic [VAL_W-1:0] rem_q, rem_d;
  logic [3:0]       chg_coin_q, chg_coin_d;
  logic [VAL_W-1:0] src;

  function automatic logic [3:0] pick_code(input logic [VAL_W-1:0] amt);
    if (amt >= VAL_W'(C_COIN_10))     return C_CODE_10;
    else if (amt >= VAL_W'(C_COIN_5)) return C_CODE_5;
    else if (amt >= VAL_W'(C_COIN_2)) return C_CODE_2;
    else if (amt >= VAL_W'(C_COIN_1)) return C_CODE_1;
    else                              return 4'b0000;
  endfunction

  function automatic logic [VAL_W-1:0] code_val(input logic [3:0] code);
    case (code)
      C_CODE_10: return VAL_W'(C_COIN_10);
      C_CODE_5:  return VAL_W'(C_COIN_5);
      C_CODE_2:  return VAL_W'(C_COIN_2);
      C_CODE_1:  return VAL_W'(C_COIN_1);
      default:   return '0;
    endcase
  endfunction

  // The first coin is issued on the load edge so pulses start with DISPENSE
  always_comb begin
    src        = load ? amount : rem_q;
    chg_coin_d = pick_code(src);
    rem_d      = src - code_val(chg_coin_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q      <= '0;
      chg_coin_q <= '0;
    end else begin
      rem_q      <= rem_d;
      chg_coin_q <= chg_coin_d;
    end
  end

  assign chg_coin = chg_coin_q;
  assign done     = (rem_q == '0);

endmodule

`default_nettype wire

// File: rtl/vend_ctrl_n.sv
// ---------------------------------------------------------------------------
// vend_ctrl_n : vending controller - selection, credit, settle, change payout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_ctrl_n
  import vend_ctrl_n_pkg::*;
#(
  parameter int                       N_ITEMS     = 4,
  parameter int                       VAL_W       = 7,
  parameter int                       TOT_W       = 10,
  parameter logic [N_ITEMS*VAL_W-1:0] PRICES      = {7'd10, 7'd5, 7'd2, 7'd1},
  parameter int                       HOLD_CYC    = 3,
  parameter int                       TIMEOUT_CYC = 200
) (
  input logic          clk,
  input logic          rst,
  vend_ctrl_n_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HLD_W = $clog2(HOLD_CYC + 1);

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   price_q, price_d;
  logic [VAL_W-1:0]   bal_q, bal_d;
  logic [VAL_W-1:0]   change_q, change_d;
  logic [N_ITEMS-1:0] vend_q, vend_d;
  logic [N_ITEMS-1:0] item_q, item_d;
  logic               alarm_q, alarm_d;
  logic               busy_q, busy_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [HLD_W-1:0]   hold_q, hold_d;

  logic               disp_load;
  logic [VAL_W-1:0]   disp_amt;
  logic               disp_done;
  logic [3:0]         chg_coin_w;
  logic [VAL_W-1:0]   coin_v;
  logic [VAL_W:0]     bal_sum;
  logic               timeout;
  logic               settle;
  logic [VAL_W-1:0]   settle_amt;
  logic               settle_alarm;
  logic [N_ITEMS-1:0] settle_vend;
  logic               tot_inc;

  function automatic logic [VAL_W-1:0] coin_value(input logic [3:0] c);
    if (c[0])      return VAL_W'(C_COIN_1);
    else if (c[1]) return VAL_W'(C_COIN_2);
    else if (c[2]) return VAL_W'(C_COIN_5);
    else if (c[3]) return VAL_W'(C_COIN_10);
    else           return '0;
  endfunction

  // Descending scan so the lowest set bit is the last one written
  function automatic logic [N_ITEMS-1:0] lowest_onehot(input logic [N_ITEMS-1:0] s);
    logic [N_ITEMS-1:0] r;
    r = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (s[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [VAL_W-1:0] price_lookup(input logic [N_ITEMS-1:0] s);
    logic [VAL_W-1:0] p;
    p = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (s[i]) p = PRICES[i*VAL_W +: VAL_W];
    end
    return p;
  endfunction

  always_comb begin
    state_d      = state_q;
    price_d      = price_q;
    bal_d        = bal_q;
    change_d     = change_q;
    vend_d       = vend_q;
    item_d       = item_q;
    alarm_d      = alarm_q;
    total_d      = total_q;
    tmr_d        = tmr_q;
    hold_d       = hold_q;
    disp_load    = 1'b0;
    disp_amt     = '0;
    tot_inc      = 1'b0;
    settle       = 1'b0;
    settle_amt   = bal_q;
    settle_alarm = 1'b0;
    settle_vend  = '0;
    coin_v       = coin_value(bus.coin);
    bal_sum      = {1'b0, bal_q} + {1'b0, coin_v};
    timeout      = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    case (state_q)
      ST_IDLE: begin
        if (|bus.sel) begin
          price_d = price_lookup(bus.sel);
          item_d  = lowest_onehot(bus.sel);
          tmr_d   = '0;
          state_d = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (bus.cancel) begin
          settle = 1'b1;
        end else if (bus.confirm) begin
          settle = 1'b1;
          if (bal_q >= price_q) begin
            settle_amt  = bal_q - price_q;
            settle_vend = item_q;
            tot_inc     = 1'b1;
          end else begin
            settle_alarm = 1'b1;
          end
        end else if (coin_v != '0) begin
          bal_d = bal_sum[VAL_W] ? '1 : bal_sum[VAL_W-1:0];
          tmr_d = '0;
        end else if (timeout) begin
          settle       = 1'b1;
          settle_alarm = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end

        // Nothing to pay out skips DISPENSE entirely
        if (settle) begin
          change_d  = settle_amt;
          alarm_d   = settle_alarm;
          vend_d    = settle_vend;
          disp_load = 1'b1;
          disp_amt  = settle_amt;
          hold_d    = '0;
          state_d   = (settle_amt == '0) ? ST_HOLD : ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (disp_done) begin
          hold_d  = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q == HLD_W'(HOLD_CYC - 1)) begin
          state_d  = ST_IDLE;
          price_d  = '0;
          bal_d    = '0;
          change_d = '0;
          vend_d   = '0;
          alarm_d  = 1'b0;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tot_inc)         total_d = total_q + TOT_W'(price_q);
    if (bus.reset_total) total_d = '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      price_q  <= '0;
      bal_q    <= '0;
      change_q <= '0;
      vend_q   <= '0;
      item_q   <= '0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
      total_q  <= '0;
      tmr_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      price_q  <= price_d;
      bal_q    <= bal_d;
      change_q <= change_d;
      vend_q   <= vend_d;
      item_q   <= item_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
      total_q  <= total_d;
      tmr_q    <= tmr_d;
      hold_q   <= hold_d;
    end
  end

  vend_change_disp #(
    .VAL_W (VAL_W)
  ) u_change_disp (
    .clk      (clk),
    .rst      (rst),
    .load     (disp_load),
    .amount   (disp_amt),
    .chg_coin (chg_coin_w),
    .done     (disp_done)
  );

  assign bus.price     = price_q;
  assign bus.balance   = bal_q;
  assign bus.change    = change_q;
  assign bus.vend_item = vend_q;
  assign bus.alarm     = alarm_q;
  assign bus.busy      = busy_q;
  assign bus.chg_coin  = chg_coin_w;
  assign bus.total     = total_q;

endmodule

`default_nettype wire
